// File: rtl/quad_enc_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | quad_enc_gen : programmable quadrature step generator (A/B tach)       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module quad_enc_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       stepce,
  input  logic [7:0] wrtdata,
  input  logic       ldcountl,
  input  logic       ldcounth,
  input  logic       ldrate,
  input  logic       start,
  input  logic       abort,
  input  logic       dir,
  input  logic       invphase,
  output logic [1:0] tach,
  output logic       busy,
  output logic       done,
  output logic [7:0] remainl,
  output logic [7:0] remainh
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_count;
  logic [7:0]  r_rate;
  logic [15:0] r_remaining;
  logic [7:0]  r_divcnt;
  logic [1:0]  r_phase;
  logic        r_dir;
  logic        r_done;

  logic        w_start_move;
  logic        w_zero_start;
  logic        w_step;
  logic        w_div_dec;
  logic        w_finish;

  // Gray-code walk: forward 00->01->11->10, reverse is the mirror.
  function automatic logic [1:0] f_next_phase(input logic [1:0] ph, input logic rev);
    logic [1:0] nx;
    case (ph)
      2'b00:   nx = rev ? 2'b10 : 2'b01;
      2'b01:   nx = rev ? 2'b00 : 2'b11;
      2'b11:   nx = rev ? 2'b01 : 2'b10;
      default: nx = rev ? 2'b11 : 2'b00;
    endcase
    return nx;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_start_move = 1'b0;
    w_zero_start = 1'b0;
    w_step       = 1'b0;
    w_div_dec    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (r_count == 16'd0) begin
            w_zero_start = 1'b1;
          end else if (!abort) begin
            w_start_move = 1'b1;
            w_state_nxt  = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Abort wins over any step that would land in the same cycle.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (stepce) begin
          if (r_divcnt == 8'd0) begin
            w_step = 1'b1;
            if (r_remaining == 16'd1) begin
              w_finish    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_div_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 16'd0;
      r_rate      <= 8'd0;
      r_remaining <= 16'd0;
      r_divcnt    <= 8'd0;
      r_phase     <= 2'b00;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (ldcountl) r_count[7:0]  <= wrtdata;
        if (ldcounth) r_count[15:8] <= wrtdata;
        if (ldrate)   r_rate        <= wrtdata;
      end
      if (w_start_move) begin
        r_remaining <= r_count;
        r_divcnt    <= r_rate;
        r_dir       <= dir;
      end
      if (w_div_dec) begin
        r_divcnt <= r_divcnt - 8'd1;
      end
      if (w_step) begin
        r_phase     <= f_next_phase(r_phase, r_dir);
        r_remaining <= r_remaining - 16'd1;
        r_divcnt    <= r_rate;
      end
      // Masking with the previous pulse keeps a held zero-count start from stretching done.
      r_done <= (w_zero_start | w_finish) & ~r_done;
    end
  end

  assign tach    = invphase ? {r_phase[0], r_phase[1]} : r_phase;
  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign remainl = r_remaining[7:0];
  assign remainh = r_remaining[15:8];

endmodule
`default_nettype wire

// File: doc/quad_enc_gen.md
QUAD_ENC_GEN -- requirements
Module: quadencgen

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: stepce  in  1  step-rate clock enable; sets generator timebase.
REQ-004 SHALL have: wrtdata  in  8  write data bus.
REQ-005 SHALL have: ldcountl / ldcounth  in  1 each  load wrtdata into step-count low / high byte.
REQ-006 SHALL have: ldrate  in  1  load wrtdata into rate divisor.
REQ-007 SHALL have: start  in  1  begin a move; abort  in  1  terminate a move.
REQ-008 SHALL have: dir  in  1  0 = forward, 1 = reverse; invphase  in  1  swap output phases.
REQ-009 SHALL have: tach  out  2  quadrature output {B,A}; busy  out  1  move in progress; done  out  1  one-cycle completion pulse.
REQ-010 SHALL have: remainl / remainh  out  8 each  remaining step count, low / high byte.

Function
REQ-011 SHALL hold registers: count[15:0], rate[7:0], remaining[15:0], divcnt[7:0], phase[1:0], latched direction, state.
REQ-012 SHALL load count and rate only in IDLE; loads in RUN are ignored; ldcountl and ldcounth together write wrtdata to both bytes.
REQ-013 SHALL implement two states: IDLE, RUN; busy = (state == RUN).
REQ-014 IDLE + start + count != 0 + no abort: next cycle RUN, remaining <= count, divcnt <= rate, direction <= dir.
REQ-015 IDLE + start + count == 0: stay IDLE, done = 1 for exactly the next cycle.
REQ-016 RUN, stepce = 1, divcnt != 0: divcnt decrements; no step.
REQ-017 RUN, stepce = 1, divcnt == 0: one step -- phase advances one position, remaining decrements, divcnt <= rate; step period is therefore rate+1 stepce pulses (rate 0 = every stepce).
REQ-018 RUN, stepce = 0: all state held.
REQ-019 Forward phase sequence: 00 -> 01 -> 11 -> 10 -> 00 (A leads B); reverse is exact opposite order.
REQ-020 Step that brings remaining to 0: next cycle IDLE, busy = 0, done = 1 for one cycle.
REQ-021 RUN + abort: next cycle IDLE, no done pulse, phase and remaining hold current values; abort overrides a same-cycle step and a same-cycle start.
REQ-022 phase SHALL persist across moves (no reset on start), so consecutive moves are continuous quadrature.
REQ-023 tach = phase when invphase = 0, {phase[0],phase[1]} when invphase = 1; combinational from phase, so invphase takes effect same cycle.
REQ-024 remainl/remainh SHALL reflect remaining register live; remaining unchanged in IDLE until next start.
REQ-025 start while in RUN SHALL be ignored; dir changes during RUN SHALL be ignored.
REQ-026 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 reset = 1: state IDLE, count 0, rate 0, remaining 0, divcnt 0, phase 00, busy 0, done 0, tach 00; reset overrides all other inputs, including mid-move.

Verification
REQ-028 Reset mid-move (count 100, 5 steps taken) -> next cycle tach 00, busy 0, remain 0, done 0.
REQ-029 count 4, rate 0, dir 0, stepce held 1, start -> tach 01,11,10,00 on four consecutive cycles; busy high 4 cycles; done one pulse after final step; remain 0.
REQ-030 count 2, rate 2, dir 1, stepce held 1, from phase 00 -> tach 10 then 11, three cycles apart; done after second step.
REQ-031 count 10, rate 0, abort after 3 steps -> busy low next cycle, remain = 7, no done, tach holds 10.
REQ-032 invphase 1, count 4, forward -> tach 10,11,01,00; toggling invphase while idle swaps tach bits same cycle.
REQ-033 count 0 + start -> single done pulse, busy never high; ldcountl during RUN -> count unchanged, verified by second start.
